mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Shares the byte-addressed SPRAM wrapper between two requesters: port A (CPU
//  load/store unit) and port B (UART loader/debug).
//  Turns 1/2/4/8-byte big-endian accesses into byte-serial memory cycles.
//  Arbitrates between A and B and returns assembled read data.
//  Sits directly between the requesters and the mem wrapper, which is its only
//  memory client.
// PARAMETERS
//  ADDR_W   15  byte-address width; must match the mem wrapper
//  RR       1   1 = round-robin on ties; 0 = fixed priority, A wins
// PORTS
//  clk        in   1       single clock
//  rst        in   1       asynchronous, active-high reset
//  a_req      in   1       A: request; held with fields stable until a_done
//  a_write    in   1       A: 1 = store, 0 = load
//  a_size     in   2       A: size_t (0 byte, 1 word=2B, 2 long=4B, 3 quad=8B)
//  a_addr     in   ADDR_W  A: byte address of the most significant byte
//  a_wdata    in   64      A: store data, low N bytes used
//  a_done     out  1       A: one-cycle completion pulse
//  a_err      out  1       A: valid with a_done; 1 = misaligned, no access made
//  a_rdata    out  64      A: load data, zero-extended; registered
//  b_*                     same set of signals for port B
//  mem_addr   out  ADDR_W  to mem.addr
//  mem_write  out  1       to mem.write
//  mem_wdata  out  8       to mem.data_in
//  mem_rdata  in   8       from mem.data_out; valid the cycle after its address
// BEHAVIOUR
//  - Reset values:
//    - state=IDLE; a_done, b_done, a_err, b_err = 0
//    - a_rdata, b_rdata = 0; mem_write = 0, mem_addr = 0, mem_wdata = 0
//    - last_grant = B, so A wins the first tie.
//  - N = 1 << size.
//  - Arbitration: only in IDLE.
//    - One request: grant it.
//    - Both requesting: RR=1 grants the port not in last_grant; RR=0 grants A.
//    - Grant edge E0 latches port, write, N, addr, wdata and updates last_grant.
//  - Alignment: addr & (N-1) != 0 -> IDLE->DONE at E0, err=1, no mem cycle.
//    rdata is unchanged.
//  - States IDLE -> XFER -> (DRAIN, reads only) -> DONE -> IDLE.
//    - A byte counter k (3 bits) runs 0..N-1 in XFER.
//  - Cycle t = t-th cycle after E0.
//  - WRITE: cycles 1..N
//    - mem_write=1, mem_addr=addr+k, mem_wdata=wdata byte (N-1-k).
//    - Big-endian: the lowest address gets the most significant byte.
//    - done in cycle N+1.
//  - READ: cycles 1..N
//    - mem_addr=addr+k, mem_write=0.
//    - mem_rdata is shifted in MSB-first at the end of cycles 2..N+1
//      (the last capture happens in DRAIN).
//    - done in cycle N+2; rdata updates in that same cycle and holds until
//      that port's next successful read.
//  - mem_* are combinational from registered state only, with no path from
//    req. mem_write=0 outside XFER.
//  - done/err go only to the latched port; the other port sees 0.
//  - DONE lasts exactly one cycle; the next grant is no earlier than the
//    following IDLE cycle.
//  - Address wrap: addr+k is computed mod 2^ADDR_W. Alignment makes wrap
//    inside one access impossible.
//  - A request dropped mid-transfer: the transfer still completes and done
//    still pulses; the requester ignores it.
//  - Reset mid-transfer:
//    - Immediate return to IDLE; mem_write falls asynchronously.
//    - A partial store may remain in memory; this is accepted.
// STRUCTURE
//  - Package mem_ctrl_pkg holds:
//    - size_t enum {SZ_BYTE, SZ_WORD, SZ_LONG, SZ_QUAD}
//    - state_t enum {IDLE, XFER, DRAIN, DONE}
//    - function size_bytes(size_t) returning N
//  - Sub-module rr_arbiter2 (req[1:0], last, RR -> grant one-hot) keeps the
//    tie rule testable alone.
//  - The mem wrapper is instantiated at top level, not inside this block.
// TESTING
//  - Quad store A @0x0010, wdata 64'h0102030405060708, then quad load A:
//    - store: bytes 01..08 at 0x10..0x17; a_done in cycle 9
//    - load: a_done in cycle 10, a_rdata=64'h0102030405060708
//  - Word load B @0x0011 -> cycle 1 b_done=1, b_err=1, mem_write never
//    asserted, b_rdata unchanged.
//  - A and B both request in the same IDLE cycle after reset:
//    - A granted first, B next.
//    - Repeat tie -> A again (alternation); RR=0 -> A every time.
//  - Byte store B @0x7FFF value 8'hAB, then long load A @0x7FFC:
//    - a_rdata = 32'h000000AB if 0x7FFC..7FFE were zeroed beforehand
//      (upper 32 bits zero)
//  - Assert rst in cycle 3 of a quad store:
//    - mem_write falls at once, state=IDLE, no done pulse
//    - the next request is served normally

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the two-port byte-serial memory controller.
// Sizes, FSM states and requester identifiers live here so every file agrees.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2,
        SZ_QUAD = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam int DATA_W = 64;

    // Number of bytes moved by an access of the given size.
    function automatic logic [3:0] size_bytes(size_t sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester-side bundle of one controller port: request fields, completion
// pulse, error flag and assembled read data.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 15
) ();

    logic              req;
    logic              write;
    size_t             size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, write, size, addr, wdata,
        input  done, err, rdata
    );

    modport slave (
        input  req, write, size, addr, wdata,
        output done, err, rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: a lone request is granted, a tie goes to the port
// that was not granted last (RR != 0) or always to port A (RR == 0).
module rr_arbiter2 #(
    parameter int RR = 1
) (
    input  logic [1:0] req,   // bit 0 = A, bit 1 = B
    input  logic       last,  // 0 = A was granted last, 1 = B
    output logic [1:0] grant  // one-hot, bit 0 = A, bit 1 = B
);

    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and infers a latch.
        grant = req;
        if (req == 2'b11) begin
            grant = ((RR != 0) && !last) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Shares a byte-wide SPRAM between requesters A and B, turning 1/2/4/8-byte
// big-endian accesses into byte-serial memory cycles.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         a,
    mem_ctrl_if.slave         b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t              state;
    port_t               port_q;
    port_t               last_q;
    logic                wr_q;
    logic [2:0]          n_m1_q;
    logic [2:0]          k_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   a_rdata_q;
    logic [DATA_W-1:0]   b_rdata_q;
    logic                a_done_q, a_err_q;
    logic                b_done_q, b_err_q;

    logic [1:0]          grant;
    logic                sel_write;
    size_t               sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [2:0]          sel_n_m1;
    logic                sel_misaligned;
    logic [2:0]          byte_idx;

    rr_arbiter2 #(.RR(RR)) u_arb (
        .req   ({b.req, a.req}),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        sel_write = a.write;
        sel_size  = a.size;
        sel_addr  = a.addr;
        sel_wdata = a.wdata;
        if (grant[1]) begin
            sel_write = b.write;
            sel_size  = b.size;
            sel_addr  = b.addr;
            sel_wdata = b.wdata;
        end
        sel_n_m1       = 3'(size_bytes(sel_size) - 4'd1);
        sel_misaligned = |(sel_addr[2:0] & sel_n_m1);
    end

    // Memory side depends only on registered state, never on a request input.
    always_comb begin
        byte_idx  = n_m1_q - k_q;
        mem_addr  = addr_q + ADDR_W'(k_q);
        mem_write = (state == XFER) && wr_q;
        mem_wdata = wdata_q[{byte_idx, 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            port_q    <= PORT_A;
            last_q    <= PORT_B;
            wr_q      <= 1'b0;
            n_m1_q    <= 3'd0;
            k_q       <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_done_q  <= 1'b0;
            a_err_q   <= 1'b0;
            b_done_q  <= 1'b0;
            b_err_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            a_done_q <= 1'b0;
            a_err_q  <= 1'b0;
            b_done_q <= 1'b0;
            b_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        port_q  <= port_t'(grant[1]);
                        last_q  <= port_t'(grant[1]);
                        wr_q    <= sel_write;
                        n_m1_q  <= sel_n_m1;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        k_q     <= 3'd0;
                        shift_q <= '0;
                        if (sel_misaligned) begin
                            state    <= DONE;
                            a_done_q <= !grant[1];
                            a_err_q  <= !grant[1];
                            b_done_q <= grant[1];
                            b_err_q  <= grant[1];
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    // Read data lags its address by one cycle, so k=0 has nothing to capture.
                    if (!wr_q && (k_q != 3'd0)) begin
                        shift_q <= {shift_q[DATA_W-9:0], mem_rdata};
                    end
                    if (k_q == n_m1_q) begin
                        if (wr_q) begin
                            state    <= DONE;
                            a_done_q <= (port_q == PORT_A);
                            b_done_q <= (port_q == PORT_B);
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                DRAIN: begin
                    state    <= DONE;
                    a_done_q <= (port_q == PORT_A);
                    b_done_q <= (port_q == PORT_B);
                    if (port_q == PORT_A) begin
                        a_rdata_q <= {shift_q[DATA_W-9:0], mem_rdata};
                    end else begin
                        b_rdata_q <= {shift_q[DATA_W-9:0], mem_rdata};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign a.done  = a_done_q;
    assign a.err   = a_err_q;
    assign a.rdata = a_rdata_q;
    assign b.done  = b_done_q;
    assign b.err   = b_err_q;
    assign b.rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: arbiter tie table plus directed
// multi-cycle sequences against a byte-wide synchronous-read memory model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int ADDR_W = 15;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) ia ();
    mem_ctrl_if #(.ADDR_W(ADDR_W)) ib ();

    mem_ctrl #(.ADDR_W(ADDR_W), .RR(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (ia),
        .b         (ib),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [1:0] arb_req;
    logic       arb_last;
    logic [1:0] g_rr;
    logic [1:0] g_fix;

    rr_arbiter2 #(.RR(1)) u_arb_rr  (.req(arb_req), .last(arb_last), .grant(g_rr));
    rr_arbiter2 #(.RR(0)) u_arb_fix (.req(arb_req), .last(arb_last), .grant(g_fix));

    // Byte-wide SPRAM: write on the edge, read data valid the cycle after its address.
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int wr_cycles = 0;
    always @(negedge clk) if (mem_write) wr_cycles++;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input logic req, input logic wr, input size_t sz,
                         input logic [ADDR_W-1:0] ad, input logic [63:0] wd);
        if (p) begin
            ib.req = req; ib.write = wr; ib.size = sz; ib.addr = ad; ib.wdata = wd;
        end else begin
            ia.req = req; ia.write = wr; ia.size = sz; ia.addr = ad; ia.wdata = wd;
        end
    endtask

    // Called at a negedge with the controller idle; checks latency, err, rdata and pulse width.
    task automatic access(input string name, input bit p, input logic wr, input size_t sz,
                          input logic [ADDR_W-1:0] ad, input logic [63:0] wd,
                          input int exp_cyc, input logic exp_err,
                          input logic [63:0] exp_rd, input bit chk_rd);
        int          cyc;
        bit          got;
        logic        er;
        logic        odn;
        logic [63:0] rd;
        got = 1'b0; cyc = 0; er = 1'b0; odn = 1'b0; rd = '0;
        drive(p, 1'b1, wr, sz, ad, wd);
        @(posedge clk);
        for (int t = 1; t <= 30 && !got; t++) begin
            @(negedge clk);
            if (p ? ib.done : ia.done) begin
                got = 1'b1;
                cyc = t;
                er  = p ? ib.err : ia.err;
                rd  = p ? ib.rdata : ia.rdata;
                odn = p ? ia.done : ib.done;
            end
        end
        drive(p, 1'b0, 1'b0, SZ_BYTE, '0, '0);
        check({name, " done seen"}, 64'(got), 64'd1);
        if (got) begin
            check({name, " cycle"}, 64'(cyc), 64'(exp_cyc));
            check({name, " err"}, 64'(er), 64'(exp_err));
            check({name, " other port done"}, 64'(odn), 64'd0);
            if (chk_rd) check({name, " rdata"}, rd, exp_rd);
            @(negedge clk);
            check({name, " done width"}, 64'(p ? ib.done : ia.done), 64'd0);
        end
    endtask

    typedef struct {
        logic [1:0] req;
        logic       last;
        logic [1:0] exp_rr;
        logic [1:0] exp_fix;
    } arb_vec_t;

    arb_vec_t arb_vecs[8];

    initial begin
        int          wc0;
        bit          which;
        bit          got;
        bit          seen;
        logic        exp_order [4];
        logic [63:0] quad;

        arb_vecs[0] = '{2'b00, 1'b0, 2'b00, 2'b00};
        arb_vecs[1] = '{2'b00, 1'b1, 2'b00, 2'b00};
        arb_vecs[2] = '{2'b01, 1'b0, 2'b01, 2'b01};
        arb_vecs[3] = '{2'b01, 1'b1, 2'b01, 2'b01};
        arb_vecs[4] = '{2'b10, 1'b0, 2'b10, 2'b10};
        arb_vecs[5] = '{2'b10, 1'b1, 2'b10, 2'b10};
        arb_vecs[6] = '{2'b11, 1'b0, 2'b10, 2'b01};
        arb_vecs[7] = '{2'b11, 1'b1, 2'b01, 2'b01};
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, SZ_BYTE, '0, '0);
        drive(1'b1, 1'b0, 1'b0, SZ_BYTE, '0, '0);
        arb_req = 2'b00; arb_last = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst a_done",    64'(ia.done),   64'd0);
        check("rst b_done",    64'(ib.done),   64'd0);
        check("rst a_err",     64'(ia.err),    64'd0);
        check("rst b_err",     64'(ib.err),    64'd0);
        check("rst a_rdata",   ia.rdata,       64'd0);
        check("rst b_rdata",   ib.rdata,       64'd0);
        check("rst mem_write", 64'(mem_write), 64'd0);
        check("rst mem_addr",  64'(mem_addr),  64'd0);
        check("rst mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;

        // Arbiter tie rule, both flavours
        for (int i = 0; i < 8; i++) begin
            arb_req  = arb_vecs[i].req;
            arb_last = arb_vecs[i].last;
            #1;
            check($sformatf("arb rr vec%0d", i),    64'(g_rr),  64'(arb_vecs[i].exp_rr));
            check($sformatf("arb fixed vec%0d", i), 64'(g_fix), 64'(arb_vecs[i].exp_fix));
        end
        @(negedge clk);

        // Quad store then quad load, big-endian
        access("A quad store", 1'b0, 1'b1, SZ_QUAD, 15'h0010, 64'h0102030405060708, 9, 1'b0, '0, 1'b0);
        quad = {mem[16], mem[17], mem[18], mem[19], mem[20], mem[21], mem[22], mem[23]};
        check("mem bytes 0x10..0x17", quad, 64'h0102030405060708);
        access("A quad load", 1'b0, 1'b0, SZ_QUAD, 15'h0010, '0, 10, 1'b0, 64'h0102030405060708, 1'b1);

        // B byte load sets b_rdata; misaligned word load must leave it alone
        access("B byte load", 1'b1, 1'b0, SZ_BYTE, 15'h0013, '0, 3, 1'b0, 64'h04, 1'b1);
        wc0 = wr_cycles;
        access("B misaligned word", 1'b1, 1'b0, SZ_WORD, 15'h0011, '0, 1, 1'b1, 64'h04, 1'b1);
        check("misaligned mem_write cycles", 64'(wr_cycles - wc0), 64'd0);

        // Tie with both held: A first after reset, then alternation
        drive(1'b0, 1'b1, 1'b0, SZ_BYTE, 15'h0010, '0);
        drive(1'b1, 1'b1, 1'b0, SZ_BYTE, 15'h0011, '0);
        for (int i = 0; i < 4; i++) begin
            got = 1'b0; which = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                @(negedge clk);
                if (ia.done || ib.done) begin
                    got   = 1'b1;
                    which = ib.done;
                    check($sformatf("tie%0d exclusive done", i), 64'(ia.done & ib.done), 64'd0);
                end
            end
            check($sformatf("tie%0d done seen", i), 64'(got), 64'd1);
            if (got) begin
                check($sformatf("tie%0d winner", i), 64'(which), 64'(exp_order[i]));
                check($sformatf("tie%0d rdata", i), which ? ib.rdata : ia.rdata, which ? 64'h02 : 64'h01);
            end
        end
        drive(1'b0, 1'b0, 1'b0, SZ_BYTE, '0, '0);
        drive(1'b1, 1'b0, 1'b0, SZ_BYTE, '0, '0);
        @(negedge clk);

        // Top of address space
        access("B byte store 7FFF", 1'b1, 1'b1, SZ_BYTE, 15'h7FFF, 64'hAB, 2, 1'b0, '0, 1'b0);
        check("mem 0x7FFF", 64'(mem[32767]), 64'hAB);
        access("A long load 7FFC", 1'b0, 1'b0, SZ_LONG, 15'h7FFC, '0, 6, 1'b0, 64'h0000_0000_0000_00AB, 1'b1);

        // Reset in cycle 3 of a quad store
        drive(1'b0, 1'b1, 1'b1, SZ_QUAD, 15'h0040, 64'h1122334455667788);
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("mid-rst mem_write before", 64'(mem_write), 64'd1);
        rst = 1'b1;
        #1;
        check("mid-rst mem_write async", 64'(mem_write), 64'd0);
        check("mid-rst state", 64'(dut.state), 64'(IDLE));
        check("mid-rst a_done", 64'(ia.done), 64'd0);
        drive(1'b0, 1'b0, 1'b0, SZ_BYTE, '0, '0);
        seen = 1'b0;
        @(negedge clk);
        seen = seen | ia.done | ib.done;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | ia.done | ib.done;
        end
        check("mid-rst no done pulse", 64'(seen), 64'd0);

        // Served normally afterwards; the two bytes written before reset remain
        access("post-rst word load", 1'b0, 1'b0, SZ_WORD, 15'h0040, '0, 4, 1'b0, 64'h1122, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
